// File: rtl/acq_ctrl_multi.sv
// Multi-channel acquisition controller: single-shot and circular
// pre-trigger capture into a dual-clock sample RAM, record held until ack.
module acq_ctrl_multi #(
  parameter int NCH        = 2,
  parameter int W          = 8,
  parameter int ADDR_W     = 10,
  parameter int NR_SAMPLES = 512,
  parameter int PRE        = 128
) (
  input  logic                ram_wr_clk,
  input  logic                reset,
  input  logic [NCH*W-1:0]    din,
  input  logic                din_valid,
  input  logic                mode,
  input  logic                arm,
  input  logic                trigger,
  input  logic                abort,
  input  logic                rec_ack,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [NCH*W-1:0]    wr_data,
  output logic                busy,
  output logic                rec_done,
  output logic [ADDR_W-1:0]   rec_start,
  output logic                trig_early
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [ADDR_W:0]   NR_C   = (ADDR_W+1)'(NR_SAMPLES);
  localparam logic [ADDR_W:0]   PRE_C  = (ADDR_W+1)'(PRE);
  localparam logic [ADDR_W:0]   POST_C = (ADDR_W+1)'(NR_SAMPLES - PRE);
  localparam logic [ADDR_W-1:0] PRE_A  = ADDR_W'(PRE);

  state_t              state;
  state_t              state_n;
  logic                mode_q;
  logic                mode_n;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]   ptr_n;
  logic [ADDR_W:0]     fill;
  logic [ADDR_W:0]     fill_n;
  logic [ADDR_W:0]     cnt;
  logic [ADDR_W:0]     cnt_n;
  logic [ADDR_W:0]     target;
  logic [ADDR_W-1:0]   start_n;
  logic                early_n;
  logic                accept;
  logic                do_wr;

  always_ff @(posedge ram_wr_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      ptr        <= '0;
      fill       <= '0;
      cnt        <= '0;
      rec_start  <= '0;
      trig_early <= 1'b0;
    end else begin
      state      <= state_n;
      mode_q     <= mode_n;
      ptr        <= ptr_n;
      fill       <= fill_n;
      cnt        <= cnt_n;
      rec_start  <= start_n;
      trig_early <= early_n;
    end
  end

  // Post-trigger word budget depends on the mode latched at arm time.
  assign target = mode_q ? POST_C : NR_C;

  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    ptr_n   = ptr;
    fill_n  = fill;
    cnt_n   = cnt;
    start_n = rec_start;
    early_n = trig_early;
    accept  = 1'b0;
    do_wr   = 1'b0;
    if (abort) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (arm) begin
            state_n = ARM;
            mode_n  = mode;
            ptr_n   = '0;
            fill_n  = '0;
            cnt_n   = '0;
            early_n = 1'b0;
          end
        end
        ARM: begin
          accept = trigger && (!mode_q || fill == PRE_C);
          if (accept) begin
            state_n = CAPTURE;
            start_n = ptr - (mode_q ? PRE_A : '0);
            do_wr   = din_valid;
            cnt_n   = din_valid ? (ADDR_W+1)'(1) : '0;
          end else if (mode_q) begin
            if (din_valid) begin
              do_wr = 1'b1;
              if (fill != PRE_C) fill_n = fill + 1'b1;
            end
            if (trigger) early_n = 1'b1;
          end
        end
        CAPTURE: begin
          if (cnt == target) begin
            state_n = DONE;
          end else if (din_valid) begin
            do_wr = 1'b1;
            cnt_n = cnt + 1'b1;
          end
        end
        DONE: begin
          if (rec_ack) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
      if (do_wr) ptr_n = ptr + 1'b1;
    end
  end

  // Outputs are registered from next-state so they line up with the FSM.
  always_ff @(posedge ram_wr_clk or posedge reset) begin
    if (reset) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      rec_done <= 1'b0;
    end else begin
      wr_en    <= do_wr;
      busy     <= (state_n == ARM) || (state_n == CAPTURE);
      rec_done <= (state_n == DONE);
      if (do_wr) begin
        wr_addr <= ptr;
        wr_data <= din;
      end
    end
  end

endmodule

// File: tb/tb_acq_ctrl_multi.sv
// Directed bench for acq_ctrl_multi: single-shot, circular, early
// trigger, gapped valid, abort and asynchronous reset.
module tb_acq_ctrl_multi;

  localparam int NCH = 2;
  localparam int W   = 8;
  localparam int AW  = 4;
  localparam int NR  = 10;
  localparam int PRE = 3;

  logic              ram_wr_clk = 1'b0;
  logic              reset;
  logic [NCH*W-1:0]  din;
  logic              din_valid;
  logic              mode;
  logic              arm;
  logic              trigger;
  logic              abort;
  logic              rec_ack;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [NCH*W-1:0]  wr_data;
  logic              busy;
  logic              rec_done;
  logic [AW-1:0]     rec_start;
  logic              trig_early;

  int checks = 0;
  int fails  = 0;

  logic [AW-1:0]    la[$];
  logic [NCH*W-1:0] ld[$];

  acq_ctrl_multi #(
    .NCH(NCH), .W(W), .ADDR_W(AW), .NR_SAMPLES(NR), .PRE(PRE)
  ) dut (
    .ram_wr_clk(ram_wr_clk),
    .reset(reset),
    .din(din),
    .din_valid(din_valid),
    .mode(mode),
    .arm(arm),
    .trigger(trigger),
    .abort(abort),
    .rec_ack(rec_ack),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .rec_done(rec_done),
    .rec_start(rec_start),
    .trig_early(trig_early)
  );

  always #5 ram_wr_clk = ~ram_wr_clk;

  always @(negedge ram_wr_clk) begin
    if (wr_en === 1'b1) begin
      la.push_back(wr_addr);
      ld.push_back(wr_data);
    end
  end

  function automatic logic [15:0] mk(input int k);
    logic [7:0] b;
    b = k[7:0];
    return {b, ~b};
  endfunction

  task automatic tick();
    @(posedge ram_wr_clk);
    #1;
  endtask

  task automatic clr_log();
    la.delete();
    ld.delete();
  endtask

  task automatic do_ack();
    rec_ack = 1'b1;
    tick();
    rec_ack = 1'b0;
    tick();
  endtask

  task automatic arm_mode(input logic m);
    mode = m;
    arm  = 1'b1;
    tick();
    arm  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({wr_en, wr_addr, wr_data, busy, rec_done, rec_start, trig_early} !== '0) begin
      fails++;
      $display("FAIL reset_outs: got %h required 0",
               {wr_en, wr_addr, wr_data, busy, rec_done, rec_start, trig_early});
    end
  endtask

  task automatic test_single_shot();
    arm_mode(1'b0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL ss_busy: got %b required 1", busy);
    end
    clr_log();
    for (int k = 0; k < 15; k++) begin
      din = mk(k);
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    tick();
    checks++;
    if (la.size() != 10) begin
      fails++;
      $display("FAIL ss_count: got %0d required 10", la.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (la[i] !== AW'(i) || ld[i] !== mk(i)) begin
          fails++;
          $display("FAIL ss_word%0d: got %h@%0d required %h@%0d",
                   i, ld[i], la[i], mk(i), i);
        end
      end
    end
    checks++;
    if (rec_start !== 4'd0 || rec_done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL ss_done: got start=%0d done=%b busy=%b required 0 1 0",
               rec_start, rec_done, busy);
    end
    do_ack();
    checks++;
    if (rec_done !== 1'b0) begin
      fails++;
      $display("FAIL ss_ack: got %b required 0", rec_done);
    end
  endtask

  task automatic test_circular();
    arm_mode(1'b1);
    clr_log();
    for (int k = 0; k < 30; k++) begin
      din = mk(k);
      din_valid = 1'b1;
      trigger = (k == 20);
      tick();
      if (k == 20) begin
        checks++;
        if (rec_start !== 4'd1 || trig_early !== 1'b0) begin
          fails++;
          $display("FAIL circ_start: got %0d early=%b required 1 0",
                   rec_start, trig_early);
        end
      end
    end
    trigger = 1'b0;
    din_valid = 1'b0;
    tick();
    checks++;
    if (la.size() != 27) begin
      fails++;
      $display("FAIL circ_count: got %0d required 27", la.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (la[17+i] !== AW'(1 + i) || ld[17+i] !== mk(17 + i)) begin
          fails++;
          $display("FAIL circ_word%0d: got %h@%0d required %h@%0d",
                   17 + i, ld[17+i], la[17+i], mk(17 + i), 1 + i);
        end
      end
    end
    checks++;
    if (rec_done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL circ_done: got done=%b busy=%b required 1 0", rec_done, busy);
    end
    do_ack();
  endtask

  task automatic test_early_trigger();
    mode = 1'b1;
    arm = 1'b1;
    trigger = 1'b1;
    tick();
    arm = 1'b0;
    clr_log();
    tick();
    checks++;
    if (trig_early !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL early_flag: got early=%b busy=%b required 1 1", trig_early, busy);
    end
    for (int k = 0; k < 12; k++) begin
      din = mk(k);
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    trigger = 1'b0;
    tick();
    checks++;
    if (rec_start !== 4'd0) begin
      fails++;
      $display("FAIL early_start: got %0d required 0", rec_start);
    end
    checks++;
    if (la.size() != 10) begin
      fails++;
      $display("FAIL early_count: got %0d required 10", la.size());
    end else begin
      checks++;
      if (la[3] !== 4'd3 || ld[3] !== mk(3) || la[9] !== 4'd9) begin
        fails++;
        $display("FAIL early_post: got %h@%0d last@%0d required %h@3 last@9",
                 ld[3], la[3], la[9], mk(3));
      end
    end
    checks++;
    if (trig_early !== 1'b1 || rec_done !== 1'b1) begin
      fails++;
      $display("FAIL early_done: got early=%b done=%b required 1 1", trig_early, rec_done);
    end
    do_ack();
  endtask

  task automatic test_gapped();
    int k;
    arm_mode(1'b0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    clr_log();
    k = 0;
    for (int i = 0; i < 20; i++) begin
      din = mk(k);
      din_valid = (i % 2 == 0);
      if (i % 2 == 0) k++;
      tick();
    end
    din_valid = 1'b0;
    checks++;
    if (la.size() != 10) begin
      fails++;
      $display("FAIL gap_count: got %0d required 10", la.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (la[i] !== AW'(i) || ld[i] !== mk(i)) begin
          fails++;
          $display("FAIL gap_word%0d: got %h@%0d required %h@%0d",
                   i, ld[i], la[i], mk(i), i);
        end
      end
    end
    checks++;
    if (rec_done !== 1'b1) begin
      fails++;
      $display("FAIL gap_done: got %b required 1", rec_done);
    end
    do_ack();
  endtask

  task automatic test_abort();
    arm_mode(1'b0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    clr_log();
    for (int k = 0; k < 4; k++) begin
      din = mk(k);
      din_valid = 1'b1;
      tick();
    end
    abort = 1'b1;
    din = mk(4);
    tick();
    abort = 1'b0;
    din_valid = 1'b0;
    checks++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || rec_done !== 1'b0) begin
      fails++;
      $display("FAIL abort_outs: got wr_en=%b busy=%b done=%b required 0 0 0",
               wr_en, busy, rec_done);
    end
    tick();
    checks++;
    if (la.size() != 4) begin
      fails++;
      $display("FAIL abort_count: got %0d required 4", la.size());
    end
    arm_mode(1'b0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    clr_log();
    din = mk(85);
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    checks++;
    if (la.size() != 1 || la[0] !== 4'd0 || ld[0] !== mk(85)) begin
      fails++;
      $display("FAIL abort_restart: got n=%0d first@%0d required n=1 first@0",
               la.size(), la.size() > 0 ? la[0] : 4'hx);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_async_reset();
    arm_mode(1'b0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int k = 0; k < 11; k++) begin
      din = mk(k + 100);
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    tick();
    checks++;
    if (rec_done !== 1'b1 || wr_addr !== 4'd9) begin
      fails++;
      $display("FAIL rst_pre_done: got done=%b addr=%0d required 1 9", rec_done, wr_addr);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({wr_en, wr_addr, wr_data, busy, rec_done, rec_start, trig_early} !== '0) begin
      fails++;
      $display("FAIL rst_done_async: got %h required 0",
               {wr_en, wr_addr, wr_data, busy, rec_done, rec_start, trig_early});
    end
    mode = 1'b1;
    arm = 1'b1;
    trigger = 1'b1;
    tick();
    tick();
    arm = 1'b0;
    trigger = 1'b0;
    checks++;
    if (busy !== 1'b0 || trig_early !== 1'b0) begin
      fails++;
      $display("FAIL rst_ignore: got busy=%b early=%b required 0 0", busy, trig_early);
    end
    reset = 1'b0;
    tick();
    arm_mode(1'b1);
    trigger = 1'b1;
    for (int k = 0; k < 2; k++) begin
      din = mk(k + 200);
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    trigger = 1'b0;
    checks++;
    if (busy !== 1'b1 || trig_early !== 1'b1 || wr_en !== 1'b1 || wr_addr !== 4'd1) begin
      fails++;
      $display("FAIL rst_pre_arm: got busy=%b early=%b wr_en=%b addr=%0d required 1 1 1 1",
               busy, trig_early, wr_en, wr_addr);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({wr_en, wr_addr, wr_data, busy, rec_done, rec_start, trig_early} !== '0) begin
      fails++;
      $display("FAIL rst_arm_async: got %h required 0",
               {wr_en, wr_addr, wr_data, busy, rec_done, rec_start, trig_early});
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    din = '0;
    din_valid = 1'b0;
    mode = 1'b0;
    arm = 1'b0;
    trigger = 1'b0;
    abort = 1'b0;
    rec_ack = 1'b0;
    test_reset();
    test_single_shot();
    test_circular();
    test_early_trigger();
    test_gapped();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/acq_ctrl_multi.md
# acq_ctrl_multi

Parametrised multi-channel acquisition controller for the reservoir capture path. It takes deserialised per-channel sample words in the RAM write-clock domain and writes them to a dual-clock sample RAM. It supports single-shot capture and circular pre-trigger capture, and holds a completed record until the USB-side reader acknowledges it. It replaces the fixed 8-bit, single-node, single-shot write path.

## Interface
Parameters:
- NCH, 2: number of node channels packed side by side in one RAM word.
- W, 8: bits per channel sample word.
- ADDR_W, 10: RAM address width; DEPTH = 2**ADDR_W.
- NR_SAMPLES, 512: words per record; legal range 1..DEPTH.
- PRE, 128: pre-trigger words kept in circular mode; legal range 0..NR_SAMPLES-1.

Ports:
- ram_wr_clk, in, 1: write-domain clock. All logic is rising-edge.
- reset, in, 1: asynchronous, active-high.
- din, in, NCH*W: channel c occupies bits [c*W +: W].
- din_valid, in, 1: din holds a new sample word this cycle.
- mode, in, 1: 0 = single-shot, 1 = circular pre-trigger. Sampled only on the arm pulse.
- arm, in, 1: single-cycle start request. Honoured only in IDLE.
- trigger, in, 1: level input, synchronous to ram_wr_clk.
- abort, in, 1: return to IDLE from any state.
- rec_ack, in, 1: reader has finished with the record.
- wr_en, out, 1: RAM write enable, registered.
- wr_addr, out, ADDR_W: RAM write address, registered.
- wr_data, out, NCH*W: RAM write data, registered.
- busy, out, 1: high in ARM or CAPTURE.
- rec_done, out, 1: a record is complete and held.
- rec_start, out, ADDR_W: address of the first word of the record.
- trig_early, out, 1: sticky flag; a trigger arrived before the pre-trigger fill completed.

## Operation
- States: IDLE, ARM, CAPTURE, DONE. The encoding is free.
- IDLE:
  - wr_en = 0.
  - arm moves the FSM to ARM. It also latches mode, clears the write address to 0, clears the fill counter, and clears trig_early.
- ARM, mode 0:
  - No writes occur.
  - trigger = 1 moves the FSM to CAPTURE. rec_start = 0.
- ARM, mode 1:
  - Every din_valid writes din at wr_addr, then wr_addr increments modulo DEPTH.
  - The fill counter saturates at PRE.
  - trigger is accepted only when fill == PRE. On acceptance: rec_start = (current wr_addr - PRE) mod DEPTH, and the FSM moves to CAPTURE.
  - trigger with fill < PRE is ignored and sets trig_early. It is edge-independent, so a held trigger is accepted once fill reaches PRE.
  - With PRE = 0, the first trigger is accepted immediately.
- CAPTURE:
  - Each din_valid writes one word.
  - Mode 0 writes NR_SAMPLES words total. Mode 1 writes NR_SAMPLES-PRE post-trigger words.
  - The addresses wrap modulo DEPTH.
  - After the last write, the FSM moves to DONE.
- DONE:
  - rec_done = 1, wr_en = 0, and the RAM contents are frozen.
  - rec_ack moves the FSM to IDLE and clears rec_done.
- abort:
  - Forces IDLE from any state. It has priority over arm, trigger and rec_ack in the same cycle.
  - It clears rec_done, and any in-flight wr_en is suppressed on the next cycle.
- Simultaneous events:
  - arm with trigger in IDLE: enter ARM only; the trigger is evaluated from the next cycle.
  - Trigger accepted with din_valid in the same cycle (ARM, mode 1): that word is written as the first post-trigger word at rec_start + PRE.
- Arithmetic:
  - All address sums are ADDR_W bits wide, with natural wrap.
  - The word counters are ADDR_W+1 bits wide, so NR_SAMPLES = DEPTH is representable.
- Reset values: all outputs 0, state IDLE, trig_early 0.

## Timing
- Write latency: din/din_valid sampled at edge N appear on wr_data/wr_addr/wr_en after edge N, valid for RAM capture at edge N+1.
- Trigger acceptance takes effect at the edge where it is sampled. A word with din_valid at that same edge is counted as post-trigger.
- rec_done rises the cycle after the last wr_en pulse. busy falls on the same edge.
- rec_start is stable from the trigger acceptance edge until the next arm.
- rec_ack is sampled only in DONE and ignored elsewhere.
- abort and reset act within one edge. Reset acts asynchronously.

## Test plan
Bench parameters: NCH = 2, W = 8, ADDR_W = 4, NR_SAMPLES = 10, PRE = 3.

1. Single-shot, mode 0:
   - Stimulus: arm, trigger, then din = {k, ~k} for k = 0..14 with din_valid always high.
   - Response: exactly 10 writes at addresses 0..9 with data k = 0..9, rec_start = 0, rec_done high, then cleared by rec_ack.
2. Circular pre-trigger, mode 1:
   - Stimulus: arm, 20 valid words k = 0..19, trigger raised with word k = 20.
   - Response: rec_start = (20-3) mod 16 = 1, words 17..19 at addresses 1..3, post-trigger words 20..26 at addresses 4..10, rec_done after word 26.
3. Early trigger, mode 1:
   - Stimulus: trigger held high from the arm cycle.
   - Response: trig_early = 1, and capture starts only after 3 valid words. rec_start = 0, and the first post-trigger word is at address 3.
4. Gapped din_valid:
   - Stimulus: mode 0, din_valid alternating 1/0.
   - Response: 10 writes over 20 cycles, no write on invalid cycles, addresses contiguous.
5. Abort:
   - Stimulus: abort mid-CAPTURE after 4 writes, then arm again.
   - Response: wr_en low the next cycle, busy = 0, rec_done = 0. The new capture restarts at address 0.
6. Asynchronous reset:
   - Stimulus: assert reset in DONE and in the middle of ARM.
   - Response: all outputs 0 immediately. arm and trigger are ignored while reset is high.
